// File: rtl/sram_word_arbiter.sv
// Two-master word arbiter sharing one SRAM controller; one latched access at a time.
// Define SRAM_ARB_RR_EN for round-robin tie-breaking; otherwise M0 has fixed priority.
module sram_word_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_ack,
    output logic              m0_stall,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_ack,
    output logic              m1_stall,
    output logic              sram_wr_en,
    output logic              sram_rd_en,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    input  logic              sram_ready
);
    typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

    state_t            r_state, w_next;
    logic              w_load, w_done, w_win, w_win_we;
    logic [ADDR_W-1:0] w_win_addr;
    logic [DATA_W-1:0] w_win_wdata;
    logic              r_grant, r_first, r_wr_en, r_rd_en;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata, r_m0_rdata, r_m1_rdata;
    logic              r_m0_ack, r_m1_ack;

`ifdef SRAM_ARB_RR_EN
    // r_prio names the master that wins the next tie: the one not granted last.
    logic r_prio;
    assign w_win = m1_req & (~m0_req | r_prio);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_prio <= 1'b0;
        else if (w_load) r_prio <= ~w_win;
    end
`else
    assign w_win = m1_req & ~m0_req;
`endif

    assign w_win_we    = w_win ? m1_we    : m0_we;
    assign w_win_addr  = w_win ? m1_addr  : m0_addr;
    assign w_win_wdata = w_win ? m1_wdata : m0_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // The controller may still show idle-ready in the first BUSY cycle, so it is skipped.
    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_done = 1'b0;
        case (r_state)
            IDLE: if (m0_req | m1_req) begin
                w_load = 1'b1;
                w_next = BUSY;
            end
            BUSY: if (!r_first && sram_ready) begin
                w_done = 1'b1;
                w_next = GAP;
            end
            GAP:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant    <= 1'b0;
            r_first    <= 1'b0;
            r_wr_en    <= 1'b0;
            r_rd_en    <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_m0_rdata <= '0;
            r_m1_rdata <= '0;
            r_m0_ack   <= 1'b0;
            r_m1_ack   <= 1'b0;
        end else begin
            r_first  <= w_load;
            r_m0_ack <= 1'b0;
            r_m1_ack <= 1'b0;
            if (w_load) begin
                r_grant <= w_win;
                r_wr_en <= w_win_we;
                r_rd_en <= ~w_win_we;
                r_addr  <= w_win_addr;
                r_wdata <= w_win_wdata;
            end
            if (w_done) begin
                r_wr_en <= 1'b0;
                r_rd_en <= 1'b0;
                if (r_grant) begin
                    r_m1_ack <= 1'b1;
                    if (r_rd_en) r_m1_rdata <= sram_rdata;
                end else begin
                    r_m0_ack <= 1'b1;
                    if (r_rd_en) r_m0_rdata <= sram_rdata;
                end
            end
        end
    end

    assign sram_wr_en = r_wr_en;
    assign sram_rd_en = r_rd_en;
    assign sram_addr  = r_addr;
    assign sram_wdata = r_wdata;
    assign m0_rdata   = r_m0_rdata;
    assign m1_rdata   = r_m1_rdata;
    assign m0_ack     = r_m0_ack;
    assign m1_ack     = r_m1_ack;
    assign m0_stall   = m0_req & ~r_m0_ack;
    assign m1_stall   = m1_req & ~r_m1_ack;
endmodule

// File: tb/tb_sram_word_arbiter.sv
// Bench for sram_word_arbiter: 6-cycle controller model, transaction-level reference
// model compared every cycle, plus hand-computed latency/data/order expectations.
module tb_sram_word_arbiter;
    localparam int LAT = 6;
`ifdef SRAM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_we, m0_ack, m0_stall;
    logic        m1_req, m1_we, m1_ack, m1_stall;
    logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
    logic        sram_wr_en, sram_rd_en, sram_ready;
    logic [31:0] sram_addr, sram_wdata, sram_rdata;

    int   n_chk = 0, n_pass = 0, cyc = 0;
    bit   chk_on = 1'b0;
    logic force_rdy = 1'b0, mem_clr = 1'b1;
    int   order[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sram_word_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_stall(m0_stall),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_stall(m1_stall),
        .sram_wr_en(sram_wr_en), .sram_rd_en(sram_rd_en), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_ready(sram_ready)
    );

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return 32'hA5A5_0000 | {26'd0, a[5:0]};
    endfunction

    // Controller: ready in the 6th cycle after enables rise, and while idle.
    logic [3:0]  c_cnt;
    logic [31:0] cmem [64];
    logic [63:0] cvld;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) c_cnt <= '0;
        else begin
            c_cnt <= (sram_wr_en | sram_rd_en) ? c_cnt + 4'd1 : 4'd0;
            if (mem_clr) cvld <= '0;
            else if (sram_wr_en && c_cnt == 4'(LAT - 1)) begin
                cmem[sram_addr[5:0]] <= sram_wdata;
                cvld[sram_addr[5:0]] <= 1'b1;
            end
        end
    end
    assign sram_ready = ~(sram_wr_en | sram_rd_en) | (c_cnt == 4'(LAT - 1)) | force_rdy;
    assign sram_rdata = cvld[sram_addr[5:0]] ? cmem[sram_addr[5:0]] : dflt(sram_addr);

    // Reference model: an access owns the port for LAT edges from its grant, then one dead cycle.
    logic [1:0]  e_ack;
    logic [31:0] e_rd0, e_rd1, e_addr, e_wdata;
    logic        e_wr, e_rd, mbusy, mgap, mprio, mw, mwe, w_p;
    int          mgrant;
    logic [31:0] mmem [64];
    logic [63:0] mvld;

    function automatic logic pick(input logic r0, input logic r1, input logic p);
        if (r0 && r1) return RR ? p : 1'b0;
        return r1;
    endfunction
    function automatic logic [31:0] mread(input logic [31:0] a);
        return mvld[a[5:0]] ? mmem[a[5:0]] : dflt(a);
    endfunction
    assign w_p = pick(m0_req, m1_req, mprio);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_ack <= '0; e_rd0 <= '0; e_rd1 <= '0; e_wr <= 1'b0; e_rd <= 1'b0;
            e_addr <= '0; e_wdata <= '0; mbusy <= 1'b0; mgap <= 1'b0;
            mprio <= 1'b0; mw <= 1'b0; mwe <= 1'b0; mgrant <= 0;
        end else begin
            e_ack <= '0;
            if (mem_clr) mvld <= '0;
            if (mbusy) begin
                if (cyc == mgrant + LAT) begin
                    mbusy <= 1'b0; mgap <= 1'b1; e_wr <= 1'b0; e_rd <= 1'b0;
                    e_ack <= mw ? 2'b10 : 2'b01;
                    if (mwe) begin
                        mmem[e_addr[5:0]] <= e_wdata;
                        mvld[e_addr[5:0]] <= 1'b1;
                    end else if (mw) e_rd1 <= mread(e_addr);
                    else             e_rd0 <= mread(e_addr);
                end
            end else if (mgap) mgap <= 1'b0;
            else if (m0_req || m1_req) begin
                mbusy   <= 1'b1;
                mgrant  <= cyc;
                mw      <= w_p;
                mwe     <= w_p ? m1_we : m0_we;
                e_wr    <= w_p ? m1_we : m0_we;
                e_rd    <= ~(w_p ? m1_we : m0_we);
                e_addr  <= w_p ? m1_addr : m0_addr;
                e_wdata <= w_p ? m1_wdata : m0_wdata;
                mprio   <= ~w_p;
            end
        end
    end

    task automatic chk(input string name, input logic [133:0] act, input logic [133:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    always @(negedge clk) if (chk_on)
        chk("cycle", {m0_ack, m1_ack, m0_stall, m1_stall, sram_wr_en, sram_rd_en,
                      sram_addr, sram_wdata, m0_rdata, m1_rdata},
                     {e_ack[0], e_ack[1], m0_req & ~e_ack[0], m1_req & ~e_ack[1], e_wr, e_rd,
                      e_addr, e_wdata, e_rd0, e_rd1});

    // One request on master m; lat = edges from grant to ack (meaningful when running alone).
    task automatic access(input bit m, input logic we, input logic [31:0] a, input logic [31:0] d,
                          input bit glitch, output int lat, output int ackc, output logic [31:0] rd);
        int g = -1;
        bit done = 1'b0;
        lat = -1; ackc = -1; rd = '0;
        if (m) begin m1_we = we; m1_addr = a; m1_wdata = d; m1_req = 1'b1; end
        else   begin m0_we = we; m0_addr = a; m0_wdata = d; m0_req = 1'b1; end
        for (int t = 0; t < 60 && !done; t++) begin
            @(posedge clk); #2;
            if (g < 0 && (sram_wr_en || sram_rd_en)) begin
                g = cyc;
                if (glitch) force_rdy = 1'b1;
            end else if (glitch) force_rdy = 1'b0;
            if (m ? m1_ack : m0_ack) begin
                done = 1'b1; ackc = cyc; lat = ackc - g;
                rd = m ? m1_rdata : m0_rdata;
                order.push_back(int'(m));
            end
        end
        if (!done) begin
            n_chk++;
            $display("FAIL ack_timeout m%0d: got no ack expected ack within 60 cycles", m);
        end
        if (m) m1_req = 1'b0; else m0_req = 1'b0;
        @(posedge clk); #2;
    endtask

    initial begin
        int          lat, lat1, ac0, ac1, rsc;
        logic [31:0] rd, rd1;
        int          exp_ord[6];
        rst_n = 1'b0; m0_req = 1'b0; m1_req = 1'b0; m0_we = 1'b0; m1_we = 1'b0;
        m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
        #3;
        chk("reset_outputs", 134'({m0_ack, m1_ack, sram_wr_en, sram_rd_en, sram_addr,
                                  sram_wdata, m0_rdata, m1_rdata}), 134'd0);
        m0_req = 1'b1; #1;
        chk("reset_stall_follows_req", 134'(m0_stall), 134'd1);
        m0_req = 1'b0;
        @(posedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #2 mem_clr = 1'b0; chk_on = 1'b1;

        // M0 write, then M1 reads it back
        access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, lat, ac0, rd);
        chk("wr_ack_latency", 134'(lat), 134'd6);
        access(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, lat, ac1, rd);
        chk("rd_ack_latency", 134'(lat), 134'd6);
        chk("m1_rdata", 134'(rd), 134'hDEADBEEF);
        chk("m0_rdata_unchanged", 134'(m0_rdata), 134'd0);

        // Three back-to-back ties
        order.delete();
        fork
            for (int k = 0; k < 3; k++) access(1'b0, 1'b1, 32'h30 + k, 32'h1000 + k, 1'b0, lat, ac0, rd);
            for (int k = 0; k < 3; k++) access(1'b1, 1'b0, 32'h30 + k, 32'h0, 1'b0, lat1, ac1, rd1);
        join
        if (RR) exp_ord = '{0, 1, 0, 1, 0, 1};
        else    exp_ord = '{0, 0, 0, 1, 1, 1};
        chk("tie_count", 134'(order.size()), 134'd6);
        for (int k = 0; k < 6 && k < order.size(); k++)
            chk($sformatf("tie_order_%0d", k), 134'(order[k]), 134'(exp_ord[k]));

        // Second request raised mid-BUSY
        fork
            begin
                access(1'b0, 1'b0, 32'h20, 32'h0, 1'b0, lat, ac0, rd);
                chk("gap_enables_low", 134'({sram_wr_en, sram_rd_en}), 134'd0);
            end
            begin
                repeat (3) @(posedge clk);
                #2 access(1'b1, 1'b1, 32'h21, 32'h12345678, 1'b0, lat1, ac1, rd1);
            end
        join
        chk("midbusy_m0_rdata", 134'(rd), 134'hA5A50020);
        chk("midbusy_ack_spacing", 134'(ac1 - ac0), 134'd8);

        // Reset in the 3rd BUSY cycle; held req is re-granted afterwards
        rsc = 0;
        fork
            access(1'b1, 1'b0, 32'h21, 32'h0, 1'b0, lat, ac1, rd);
            begin
                for (int t = 0; t < 20 && !(sram_wr_en || sram_rd_en); t++) begin
                    @(posedge clk); #2;
                end
                repeat (2) @(posedge clk);
                #2 rst_n = 1'b0; rsc = cyc;
                #1 chk("midbusy_reset_outputs", 134'({m0_ack, m1_ack, sram_wr_en, sram_rd_en,
                        sram_addr, sram_wdata, m0_rdata, m1_rdata, m1_stall}), 134'd1);
                #1 rst_n = 1'b1;
            end
        join
        chk("reset_regrant_latency", 134'(lat), 134'd9);
        chk("reset_ack_after_reset", 134'(ac1 - rsc), 134'd7);
        chk("reset_regrant_rdata", 134'(rd), 134'h12345678);

        // Ready high in the first BUSY cycle must be ignored
        access(1'b0, 1'b0, 32'h10, 32'h0, 1'b1, lat, ac0, rd);
        chk("glitch_ack_latency", 134'(lat), 134'd6);
        chk("glitch_rdata", 134'(rd), 134'hDEADBEEF);

        repeat (2) @(posedge clk);
        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
